try: RTL and testbench
======================

TRY -- requirements
Module: try

Interface
REQ-001 Parameter DATA_W, 34, message width in bits.
REQ-002 Parameter CRC_W, 16, CRC width in bits.
REQ-003 Parameter POLY, 16'h1021, CRC-16-CCITT generator x^16+x^12+x^5+1, implicit x^16 term.
REQ-004 Parameter INIT, 16'h0000, CRC register start value.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset: 0 = reset, sampled on the clk rising edge only.
REQ-007 data_in  input  34  message word; sampled only in LOAD.
REQ-008 data_out  output  50  registered codeword {message[33:0], crc[15:0]}; message in [49:16], CRC in [15:0].

Function
REQ-009 The block SHALL be a bit-serial CRC-16 encoder with FSM states LOAD, SHIFT and DONE, a 34-bit message holding register, a 34-bit shift register, a 16-bit CRC register and a 6-bit bit counter.
REQ-010 LOAD (1 cycle) SHALL copy data_in into both the holding register and the shift register, set CRC = INIT and counter = 0, then go to SHIFT.
REQ-011 SHIFT SHALL process one bit per cycle, MSB first: b = shift[33]; fb = crc[15] XOR b; crc <= {crc[14:0],1'b0} XOR (fb ? POLY : 0); shift <= shift << 1; counter increments.
REQ-012 SHIFT SHALL last exactly 34 cycles and go to DONE on the cycle it processes bit 0 (counter = 33).
REQ-013 DONE (1 cycle) SHALL load data_out <= {holding register, crc} and go to LOAD.
REQ-014 The block SHALL run continuously; one frame takes 36 cycles (LOAD + 34 SHIFT + DONE), with no idle state and no start input.
REQ-015 data_out SHALL change only in DONE and SHALL hold its value for the other 35 cycles of each frame.
REQ-016 Changes on data_in outside LOAD SHALL NOT affect the frame in progress.
REQ-017 No reflection and no final XOR SHALL be applied; the result equals the MSB-first long division of message*x^16 by POLY with INIT preset.
REQ-018 The counter SHALL never exceed 33; an illegal FSM encoding SHALL return to LOAD on the next edge.

Reset
REQ-019 While reset = 0 at a rising edge: state <= LOAD, data_out <= 0, crc <= INIT, counter <= 0, and the shift and holding registers are cleared.
REQ-020 Reset asserted mid-frame SHALL abort the frame; no partial result may reach data_out.
REQ-021 The first edge with reset = 1 SHALL execute LOAD; the first result SHALL appear on data_out after the 36th rising edge with reset = 1.

Verification
REQ-022 data_in = 34'h0, release reset -> data_out = 0 throughout; after edge 36 data_out = 50'h0.
REQ-023 data_in = 34'h1 -> after edge 36 data_out = 50'h0_0001_1021 (CRC 16'h1021), unchanged through edge 71.
REQ-024 data_in = 34'h2 -> after edge 36 data_out = 50'h0_0002_2042 (CRC 16'h2042).
REQ-025 data_in = 34'b1010...10 (34'h2AAAAAAAA) -> after edge 36, data_out[49:16] = 34'h2AAAAAAAA and data_out[15:0] equals the software model result; the value repeats every 36 cycles.
REQ-026 Change data_in from 34'h1 to 34'h2 during SHIFT of frame 1 -> frame 1 yields CRC 16'h1021 and frame 2 yields 16'h2042.
REQ-027 Assert reset = 0 for one cycle at frame cycle 20 -> data_out = 0 on the next edge, and the next valid result appears 36 edges after reset release.

Source files
------------

// File: rtl/try.sv
// ---------------------------------------------------------------------------
// try -- free-running, bit-serial CRC-16 encoder.
//
// Each 36-cycle frame has three parts. LOAD takes one cycle and captures
// data_in. SHIFT takes DATA_W cycles and feeds the message through the CRC
// register one bit per cycle, MSB first. DONE takes one cycle and publishes
// {message, crc} on data_out. Then the next frame begins. There is no idle
// state and no start strobe. data_out is a register, and it changes only
// in DONE.
//
// The CRC is a plain MSB-first polynomial division with INIT preset. It uses
// no reflection and no final XOR.
//
// Ports
//   clk       in   1                single clock, rising-edge active
//   reset     in   1                synchronous active-low reset
//   data_in   in   DATA_W           message word, sampled only in LOAD
//   data_out  out  DATA_W+CRC_W     registered codeword {message, crc}
// ---------------------------------------------------------------------------
module try #(
  parameter int                 DATA_W = 34,
  parameter int                 CRC_W  = 16,
  parameter logic [CRC_W-1:0]   POLY   = 16'h1021,
  parameter logic [CRC_W-1:0]   INIT   = 16'h0000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         data_in,
  output logic [DATA_W+CRC_W-1:0]   data_out
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  hold_q;
  logic [DATA_W-1:0]  shift_q;
  logic [CRC_W-1:0]   crc_q;
  logic [CRC_W-1:0]   crc_next;
  logic [CNT_W-1:0]   cnt_q;
  logic               last_bit;
  logic               fb;

  // This is the cycle that processes message bit 0.
  assign last_bit = (cnt_q == CNT_W'(DATA_W - 1));

  // One step of the serial division. The implicit x^16 term is the XOR of
  // the bit leaving the register with the incoming message bit.
  assign fb       = crc_q[CRC_W-1] ^ shift_q[DATA_W-1];
  assign crc_next = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) assignments only. All
  // flops then update together on the edge, with no dependence on the
  // order in which the statements run.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= LOAD;
    else        state_q <= state_d;
  end

  // Next-state logic. The unused encoding falls back to LOAD.
  // NOTE: state_d gets its value before the case statement. Every path
  // through the block therefore assigns it, so no latch is inferred.
  always_comb begin
    state_d = LOAD;
    case (state_q)
      LOAD:    state_d = SHIFT;
      SHIFT:   state_d = last_bit ? DONE : SHIFT;
      DONE:    state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Datapath. A reset in mid-frame clears every register, so no partial
  // CRC can be published later.
  // NOTE: every register here is a flop, not a memory. Each one is cleared
  // by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_q   <= '0;
      shift_q  <= '0;
      crc_q    <= INIT;
      cnt_q    <= '0;
      data_out <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          hold_q  <= data_in;
          shift_q <= data_in;
          crc_q   <= INIT;
          cnt_q   <= '0;
        end
        SHIFT: begin
          crc_q   <= crc_next;
          shift_q <= shift_q << 1;
          // Wrap to zero instead of counting past the last bit index.
          cnt_q   <= last_bit ? '0 : cnt_q + CNT_W'(1);
        end
        DONE: begin
          data_out <= {hold_q, crc_q};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_try.sv
// ---------------------------------------------------------------------------
// tb_try -- directed self-checking bench for the serial CRC-16 encoder.
// Inputs change and outputs are sampled 1 ns after a rising edge. Edge
// numbers in the comments count rising edges after reset is released.
// ---------------------------------------------------------------------------
module tb_try;

  localparam int          DATA_W = 34;
  localparam int          CRC_W  = 16;
  localparam logic [15:0] POLY   = 16'h1021;
  localparam int          OUT_W  = DATA_W + CRC_W;

  logic               clk;
  logic               reset;
  logic [DATA_W-1:0]  data_in;
  logic [OUT_W-1:0]   data_out;

  int total = 0;
  int bad   = 0;

  try #(
    .DATA_W (DATA_W),
    .CRC_W  (CRC_W),
    .POLY   (POLY),
    .INIT   (16'h0000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference CRC: long division of m * x^16 by the full 17-bit generator.
  function automatic logic [CRC_W-1:0] crc_ref(input logic [DATA_W-1:0] m);
    logic [OUT_W-1:0] r;
    logic [OUT_W-1:0] g;
    r = {m, 16'h0000};
    g = {33'h0, 1'b1, POLY};
    for (int i = OUT_W - 1; i >= CRC_W; i--)
      if (r[i]) r = r ^ (g << (i - CRC_W));
    return r[CRC_W-1:0];
  endfunction

  task automatic check(input string tag, input logic [OUT_W-1:0] obs,
                       input logic [OUT_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold reset low for two edges. The next edge is the first with reset=1.
  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
  endtask

  // Stop a hung simulation; the limit sits far above the planned run length.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b0;
    data_in = 34'h0;
    tick(3);
    check("reset_state", data_out, '0);

    // Reset held with non-zero input: the output stays cleared.
    data_in = 34'h3_FFFF_FFFF;
    tick(2);
    check("reset_hold_nonzero_in", data_out, '0);

    // All-zero message.
    data_in = 34'h0;
    do_reset();
    tick(35);
    check("zero_before_edge36", data_out, '0);
    tick(1);
    check("zero_edge36", data_out, '0);

    // Message 1: CRC 1021. The value holds for the whole next frame.
    data_in = 34'h1;
    do_reset();
    tick(35);
    check("one_edge35_not_yet", data_out, '0);
    tick(1);
    check("one_edge36", data_out, 50'h0_0001_1021);
    tick(35);
    check("one_edge71_hold", data_out, 50'h0_0001_1021);
    tick(1);
    check("one_edge72_repeat", data_out, 50'h0_0001_1021);

    // Message 2: CRC 2042.
    data_in = 34'h2;
    do_reset();
    tick(36);
    check("two_edge36", data_out, 50'h0_0002_2042);

    // Alternating pattern against the reference model. It repeats per frame.
    data_in = 34'h2_AAAA_AAAA;
    do_reset();
    tick(36);
    check("alt_edge36", data_out, {34'h2_AAAA_AAAA, crc_ref(34'h2_AAAA_AAAA)});
    tick(20);
    check("alt_mid_frame_hold", data_out,
          {34'h2_AAAA_AAAA, crc_ref(34'h2_AAAA_AAAA)});
    tick(16);
    check("alt_edge72", data_out, {34'h2_AAAA_AAAA, crc_ref(34'h2_AAAA_AAAA)});

    // Input changes during SHIFT are ignored until the next LOAD.
    data_in = 34'h1;
    do_reset();
    tick(5);
    data_in = 34'h2;
    tick(31);
    check("chg_frame1", data_out, 50'h0_0001_1021);
    tick(36);
    check("chg_frame2", data_out, 50'h0_0002_2042);

    // A one-cycle reset at frame cycle 20 aborts the frame.
    data_in = 34'h1;
    do_reset();
    tick(36);
    check("abort_first_result", data_out, 50'h0_0001_1021);
    tick(19);
    check("abort_hold_before", data_out, 50'h0_0001_1021);
    reset = 1'b0;
    tick(1);
    check("abort_cleared", data_out, '0);
    reset   = 1'b1;
    data_in = 34'h2;
    tick(35);
    check("abort_no_partial", data_out, '0);
    tick(1);
    check("abort_next_result", data_out, 50'h0_0002_2042);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
